// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, occupancy width helper and grant encodings for single-port FIFO controllers
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    // One-hot grants: bit 0 is the push/write side, bit 1 the pop/read side.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_PUSH = 2'b01;
    localparam logic [1:0] GNT_POP  = 2'b10;

    typedef enum logic {
        LAST_PUSH = 1'b0,
        LAST_POP  = 1'b1
    } last_grant_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; rotates only when both requesters contend
module rr_arb2
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    last_grant_t last_grant;

    always_comb begin
        gnt = GNT_NONE;
        if (req == 2'b11) begin
            gnt = (last_grant == LAST_POP) ? GNT_PUSH : GNT_POP;
        end else begin
            gnt = req;
        end
    end

    // Uncontested grants leave the history alone, so the first conflict after reset goes to requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= LAST_POP;
        end else if (req == 2'b11) begin
            last_grant <= (last_grant == LAST_POP) ? LAST_PUSH : LAST_POP;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller wrapping a single-port registered-read RAM
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_req,
    input  logic [DATA_WIDTH-1:0]             push_data,
    output logic                              push_ready,
    input  logic                              pop_req,
    output logic                              pop_ready,
    output logic                              pop_valid,
    output logic [DATA_WIDTH-1:0]             pop_data,
    output logic [cnt_width(FIFO_DEPTH)-1:0]  count,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow_err,
    output logic                              underflow_err,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_wr_data,
    output logic                              ram_wren,
    output logic                              ram_rden,
    input  logic [DATA_WIDTH-1:0]             ram_rd_data
);

    localparam int                    CNT_W     = cnt_width(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [1:0]            gnt;
    logic                  push_gnt;
    logic                  pop_gnt;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push_req & ~full;
    assign pop_ok  = pop_req & ~empty;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({pop_ok, push_ok}),
        .gnt (gnt)
    );

    assign push_gnt    = (gnt == GNT_PUSH);
    assign pop_gnt     = (gnt == GNT_POP);
    assign push_ready  = push_gnt;
    assign pop_ready   = pop_gnt;
    assign ram_wren    = push_gnt;
    assign ram_rden    = pop_gnt;
    assign ram_wr_data = push_data;
    assign pop_data    = ram_rd_data;

    always_comb begin
        ram_addr = '0;
        if (push_gnt) begin
            ram_addr = wr_ptr;
        end else if (pop_gnt) begin
            ram_addr = rd_ptr;
        end
    end

    // The RAM registers its read, so pop_valid is simply the pop grant delayed by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pop_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pop_valid <= pop_gnt;
            if (push_gnt) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + ADDR_WIDTH'(1);
                count  <= count + CNT_W'(1);
            end else if (pop_gnt) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + ADDR_WIDTH'(1);
                count  <= count - CNT_W'(1);
            end
            if (push_req && full) begin
                overflow_err <= 1'b1;
            end
            if (pop_req && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
